// File: rtl/soc_ifc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_ifc_pkg
// Purpose  : State encodings shared by the SoC-interface reset sequencer.
// Revision : 1.0
// ============================================================================
package soc_ifc_pkg;

    typedef enum logic [1:0] {
        BOOT_IDLE  = 2'd0,
        BOOT_FUSE  = 2'd1,
        BOOT_BRKPT = 2'd2,
        BOOT_DONE  = 2'd3
    } boot_seq_state_e;

    typedef enum logic [1:0] {
        DOM_HOLD  = 2'd0,
        DOM_RUN   = 2'd1,
        DOM_FWRST = 2'd2,
        DOM_WAIT  = 2'd3
    } dom_state_e;

endpackage : soc_ifc_pkg
`default_nettype wire

// File: rtl/soc_ifc_rst_dom_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : soc_ifc_rst_dom_ctrl
// Purpose  : One core reset domain: FW-update reset FSM, hold-off counter,
//            sticky executed flag and reset synchroniser chain.
// Revision : 1.0
// ============================================================================
module soc_ifc_rst_dom_ctrl
    import soc_ifc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_W      = 8
) (
    input  logic              clk,
    input  logic              cptra_rst_b,
    input  logic              boot_done_i,
    input  logic              brkpt_i,
    input  logic              brkpt_continue_i,
    input  logic              rst_req_i,
    input  logic [WAIT_W-1:0] wait_cycles_i,
    output logic              rst_b_o,
    output logic              unlock_o,
    output logic              rst_executed_o,
    output logic              rst_window_o
);

    localparam logic [WAIT_W-1:0] c_cnt_one = WAIT_W'(1);

    dom_state_e             state_q;
    logic [WAIT_W-1:0]      cnt_q;
    logic                   unlock_q;
    logic                   executed_q;
    logic                   window_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_req_d;
    logic                   stall;

    assign rst_req_d = (state_q == DOM_RUN);
    assign stall     = brkpt_i & ~brkpt_continue_i;

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state_q    <= DOM_HOLD;
            cnt_q      <= '0;
            unlock_q   <= 1'b0;
            executed_q <= 1'b0;
            window_q   <= 1'b0;
        end else begin
            unlock_q <= 1'b0;
            case (state_q)
                DOM_HOLD: begin
                    if (boot_done_i) begin
                        state_q <= DOM_RUN;
                    end
                end
                DOM_RUN: begin
                    if (rst_req_i) begin
                        state_q    <= DOM_FWRST;
                        executed_q <= 1'b1;
                        window_q   <= 1'b1;
                    end
                end
                DOM_FWRST: begin
                    // Wait for the whole chain to drain so a 1 still in flight
                    // (request taken on the first RUN cycle) cannot leak into WAIT.
                    if (sync_q == '0) begin
                        state_q  <= DOM_WAIT;
                        cnt_q    <= wait_cycles_i;
                        window_q <= 1'b0;
                    end
                end
                DOM_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - c_cnt_one;
                    end else if (!stall) begin
                        state_q  <= DOM_RUN;
                        unlock_q <= 1'b1;
                    end
                end
                default: state_q <= DOM_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rst_req_d};
        end
    end

    assign rst_b_o        = sync_q[SYNC_STAGES-1];
    assign unlock_o       = unlock_q;
    assign rst_executed_o = executed_q;
    assign rst_window_o   = window_q;

    a_dom_known: assert property (@(posedge clk) disable iff (!cptra_rst_b)
        !$isunknown({state_q, cnt_q, unlock_q, executed_q, window_q, sync_q}));

    a_dom_held_in_wait: assert property (@(posedge clk) disable iff (!cptra_rst_b)
        (state_q == DOM_WAIT) |-> !rst_b_o);

    a_dom_unlock_from_run: assert property (@(posedge clk) disable iff (!cptra_rst_b)
        unlock_o |-> (state_q == DOM_RUN));

endmodule : soc_ifc_rst_dom_ctrl
`default_nettype wire

// File: rtl/soc_ifc_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : soc_ifc_rst_seq
// Purpose  : Boot/reset sequencer: fuse handshake, debug breakpoint, non-core
//            reset release and NUM_DOM independent core reset domains.
// Revision : 1.0
// ============================================================================
module soc_ifc_rst_seq
    import soc_ifc_pkg::*;
#(
    parameter int NUM_DOM     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_W      = 8
) (
    input  logic               clk,
    input  logic               cptra_rst_b,
    input  logic               fuse_done,
    input  logic               fuse_wr_done_observed,
    input  logic               brkpt,
    input  logic               brkpt_continue,
    input  logic [NUM_DOM-1:0] dom_rst_req,
    input  logic [WAIT_W-1:0]  wait_cycles,
    output logic               ready_for_fuses,
    output logic               noncore_rst_b,
    output logic [NUM_DOM-1:0] dom_rst_b,
    output logic [NUM_DOM-1:0] dom_unlock,
    output logic [NUM_DOM-1:0] dom_rst_executed,
    output logic [NUM_DOM-1:0] dom_rst_window
);

    boot_seq_state_e        boot_state_q;
    logic                   ready_q;
    logic                   noncore_req_d;
    logic [SYNC_STAGES-1:0] noncore_sync_q;
    logic [NUM_DOM-1:0]     dom_sync_rst_b;

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            boot_state_q <= BOOT_IDLE;
            ready_q      <= 1'b0;
        end else begin
            case (boot_state_q)
                BOOT_IDLE: begin
                    boot_state_q <= BOOT_FUSE;
                    ready_q      <= 1'b1;
                end
                BOOT_FUSE: begin
                    if (fuse_done && fuse_wr_done_observed) begin
                        boot_state_q <= brkpt ? BOOT_BRKPT : BOOT_DONE;
                        ready_q      <= 1'b0;
                    end
                end
                BOOT_BRKPT: begin
                    if (brkpt_continue) begin
                        boot_state_q <= BOOT_DONE;
                    end
                end
                default: ;  // DONE is terminal until the next cptra_rst_b
            endcase
        end
    end

    assign noncore_req_d = (boot_state_q == BOOT_DONE);

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            noncore_sync_q <= '0;
        end else begin
            noncore_sync_q <= {noncore_sync_q[SYNC_STAGES-2:0], noncore_req_d};
        end
    end

    assign ready_for_fuses = ready_q;
    assign noncore_rst_b   = noncore_sync_q[SYNC_STAGES-1];

    generate
        for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
            soc_ifc_rst_dom_ctrl #(
                .SYNC_STAGES (SYNC_STAGES),
                .WAIT_W      (WAIT_W)
            ) u_dom_ctrl (
                .clk              (clk),
                .cptra_rst_b      (cptra_rst_b),
                .boot_done_i      (noncore_req_d),
                .brkpt_i          (brkpt),
                .brkpt_continue_i (brkpt_continue),
                .rst_req_i        (dom_rst_req[i]),
                .wait_cycles_i    (wait_cycles),
                .rst_b_o          (dom_sync_rst_b[i]),
                .unlock_o         (dom_unlock[i]),
                .rst_executed_o   (dom_rst_executed[i]),
                .rst_window_o     (dom_rst_window[i])
            );
        end
    endgenerate

    // A domain can only be out of reset while the non-core is out of reset.
    assign dom_rst_b = dom_sync_rst_b & {NUM_DOM{noncore_rst_b}};

    a_top_known: assert property (@(posedge clk) disable iff (!cptra_rst_b)
        !$isunknown({boot_state_q, ready_q, noncore_sync_q, dom_rst_b,
                     dom_unlock, dom_rst_executed, dom_rst_window}));

    a_noncore_held: assert property (@(posedge clk) disable iff (!cptra_rst_b)
        (boot_state_q != BOOT_DONE) |-> !noncore_rst_b);

    a_ready_in_fuse: assert property (@(posedge clk) disable iff (!cptra_rst_b)
        ready_for_fuses == (boot_state_q == BOOT_FUSE));

endmodule : soc_ifc_rst_seq
`default_nettype wire

// File: tb/tb_soc_ifc_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_ifc_rst_seq
// Purpose  : Self-checking bench: vector table, breakpoint/reset sequences and
//            randomized traffic against a timestamp-based reference model.
// Revision : 1.0
// ============================================================================
module tb_soc_ifc_rst_seq;

    localparam int SS  = 2;
    localparam int NV  = 30;
    localparam int INF = 1 << 30;

    logic       clk;
    logic       cptra_rst_b;
    logic       fuse_done;
    logic       fuse_wr_done_observed;
    logic       brkpt;
    logic       brkpt_continue;
    logic [1:0] dom_rst_req;
    logic [7:0] wait_cycles;
    logic       ready_for_fuses;
    logic       noncore_rst_b;
    logic [1:0] dom_rst_b;
    logic [1:0] dom_unlock;
    logic [1:0] dom_rst_executed;
    logic [1:0] dom_rst_window;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic       fd, obs, bp, bc;
        logic [1:0] req;
        logic [7:0] wt;
        logic       rdy, nc;
        logic [1:0] drb, unl, ex, win;
    } vec_t;

    vec_t vt [NV];

    soc_ifc_rst_seq #(
        .NUM_DOM     (2),
        .SYNC_STAGES (SS),
        .WAIT_W      (8)
    ) dut (
        .clk                   (clk),
        .cptra_rst_b           (cptra_rst_b),
        .fuse_done             (fuse_done),
        .fuse_wr_done_observed (fuse_wr_done_observed),
        .brkpt                 (brkpt),
        .brkpt_continue        (brkpt_continue),
        .dom_rst_req           (dom_rst_req),
        .wait_cycles           (wait_cycles),
        .ready_for_fuses       (ready_for_fuses),
        .noncore_rst_b         (noncore_rst_b),
        .dom_rst_b             (dom_rst_b),
        .dom_unlock            (dom_unlock),
        .dom_rst_executed      (dom_rst_executed),
        .dom_rst_window        (dom_rst_window)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(logic fd, logic obs, logic bp, logic bc, logic [1:0] req,
                               logic [7:0] wt, logic rdy, logic nc, logic [1:0] drb,
                               logic [1:0] unl, logic [1:0] ex, logic [1:0] win);
        vec_t r;
        r.fd = fd; r.obs = obs; r.bp = bp; r.bc = bc; r.req = req; r.wt = wt;
        r.rdy = rdy; r.nc = nc; r.drb = drb; r.unl = unl; r.ex = ex; r.win = win;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        fuse_done = 1'b0; fuse_wr_done_observed = 1'b0;
        brkpt = 1'b0; brkpt_continue = 1'b0;
        dom_rst_req = 2'b00; wait_cycles = 8'd0;
    endtask

    task automatic do_reset();
        cptra_rst_b = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        cptra_rst_b = 1'b1;
        cyc = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_all(input logic rdy, input logic nc, input logic [1:0] drb,
                           input logic [1:0] unl, input logic [1:0] ex, input logic [1:0] win);
        chk("ready_for_fuses",  32'(ready_for_fuses),  32'(rdy));
        chk("noncore_rst_b",    32'(noncore_rst_b),    32'(nc));
        chk("dom_rst_b",        32'(dom_rst_b),        32'(drb));
        chk("dom_unlock",       32'(dom_unlock),       32'(unl));
        chk("dom_rst_executed", 32'(dom_rst_executed), 32'(ex));
        chk("dom_rst_window",   32'(dom_rst_window),   32'(win));
    endtask

    // Row i: outputs expected during cycle i, then inputs sampled at the end of cycle i.
    task automatic run_table();
        for (int i = 0; i < NV; i++) begin
            chk_all(vt[i].rdy, vt[i].nc, vt[i].drb, vt[i].unl, vt[i].ex, vt[i].win);
            fuse_done = vt[i].fd; fuse_wr_done_observed = vt[i].obs;
            brkpt = vt[i].bp; brkpt_continue = vt[i].bc;
            dom_rst_req = vt[i].req; wait_cycles = vt[i].wt;
            tick();
        end
        clear_inputs();
    endtask

    // Breakpoint boot, then a domain stalled in WAIT until brkpt_continue.
    task automatic run_brkpt_seq();
        logic [1:0] e_drb;
        do_reset();
        for (int c = 0; c <= 44; c++) begin
            e_drb = (c < 24) ? 2'b00 : ((c >= 29 && c < 43) ? 2'b10 : 2'b11);
            chk_all(c >= 1 && c <= 5, c >= 23, e_drb,
                    (c == 41) ? 2'b01 : 2'b00,
                    (c >= 27) ? 2'b01 : 2'b00,
                    (c >= 27 && c <= 29) ? 2'b01 : 2'b00);
            fuse_done = (c >= 5); fuse_wr_done_observed = (c >= 5);
            brkpt = (c >= 5);
            brkpt_continue = (c == 20 || c == 40);
            dom_rst_req = (c == 26) ? 2'b01 : 2'b00;
            wait_cycles = 8'd2;
            tick();
        end
        clear_inputs();
    endtask

    // Async reset while domain 1 is in FWRST, then a full cold boot again.
    task automatic run_midreset_seq();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            fuse_done = (c >= 1); fuse_wr_done_observed = (c >= 1);
            dom_rst_req = (c == 6) ? 2'b10 : 2'b00;
            tick();
        end
        dom_rst_req = 2'b00;
        chk_all(1'b0, 1'b1, 2'b11, 2'b00, 2'b10, 2'b10);
        cptra_rst_b = 1'b0;
        #1;
        chk_all(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        clear_inputs();
        @(posedge clk);
        #1;
        chk_all(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
        cptra_rst_b = 1'b1;
        cyc = 0;
        run_table();
    endtask

    // Reference model: each domain is described by event timestamps derived
    // from the documented latencies (fall, hold-off sample, run, rise).
    task automatic run_random(input int ncyc);
        int f, k, bp, done_at;
        int run_at [2], fall_at [2], rise_at [2], samp_at [2];
        int unl_at [2], ex_from [2], win_from [2], win_to [2];
        logic [1:0] req, e_drb, e_unl, e_ex, e_win;
        logic [7:0] w;
        logic nc_e;
        do_reset();
        f  = int'($urandom_range(2, 8));
        bp = int'($urandom_range(0, 1));
        k  = f + int'($urandom_range(1, 6));
        done_at = (bp != 0) ? k + 1 : f + 1;
        for (int d = 0; d < 2; d++) begin
            run_at[d] = done_at + 1;  rise_at[d] = done_at + 1 + SS;
            fall_at[d] = INF; samp_at[d] = INF; unl_at[d] = INF;
            ex_from[d] = INF; win_from[d] = INF; win_to[d] = -1;
        end
        for (int c = 0; c < ncyc; c++) begin
            nc_e = (c >= done_at + SS);
            for (int d = 0; d < 2; d++) begin
                e_drb[d] = nc_e && c >= rise_at[d] && c < fall_at[d];
                e_unl[d] = (c == unl_at[d]);
                e_ex[d]  = (c >= ex_from[d]);
                e_win[d] = (c >= win_from[d] && c <= win_to[d]);
            end
            chk_all(c >= 1 && c <= f, nc_e, e_drb, e_unl, e_ex, e_win);
            req[0] = ($urandom_range(0, 7) == 0);
            req[1] = ($urandom_range(0, 7) == 0);
            w = 8'($urandom_range(0, 6));
            fuse_done = (c >= f - 1); fuse_wr_done_observed = (c >= f);
            brkpt = (bp != 0) && c >= f && c < k;
            brkpt_continue = (bp != 0) && c == k;
            dom_rst_req = req; wait_cycles = w;
            for (int d = 0; d < 2; d++) begin
                if (req[d] && c >= run_at[d]) begin
                    fall_at[d] = c + 1 + SS;
                    samp_at[d] = c + 1 + SS;
                    win_from[d] = c + 1;  win_to[d] = c + 1 + SS;
                    if (ex_from[d] == INF) ex_from[d] = c + 1;
                    run_at[d] = INF;
                end else if (c == samp_at[d]) begin
                    run_at[d]  = c + 2 + int'(w);
                    unl_at[d]  = run_at[d];
                    rise_at[d] = run_at[d] + SS;
                    fall_at[d] = INF;
                    samp_at[d] = INF;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        cptra_rst_b = 1'b0;
        clear_inputs();
        //            fd obs bp bc req   wt     rdy nc drb    unl    ex     win
        vt[0]  = v(0, 0, 0, 0, 2'b00, 8'd0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[1]  = v(0, 0, 0, 0, 2'b00, 8'd0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[2]  = v(1, 0, 0, 0, 2'b00, 8'd0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[3]  = v(0, 1, 0, 0, 2'b00, 8'd0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[4]  = v(0, 0, 0, 0, 2'b00, 8'd0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[5]  = v(1, 1, 0, 0, 2'b00, 8'd0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[6]  = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[7]  = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[8]  = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        vt[9]  = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00);
        vt[10] = v(1, 1, 0, 0, 2'b01, 8'd3, 0, 1, 2'b11, 2'b00, 2'b00, 2'b00);
        vt[11] = v(1, 1, 0, 0, 2'b00, 8'd3, 0, 1, 2'b11, 2'b00, 2'b01, 2'b01);
        vt[12] = v(1, 1, 0, 0, 2'b00, 8'd3, 0, 1, 2'b11, 2'b00, 2'b01, 2'b01);
        vt[13] = v(1, 1, 0, 0, 2'b00, 8'd3, 0, 1, 2'b10, 2'b00, 2'b01, 2'b01);
        vt[14] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b10, 2'b00, 2'b01, 2'b00);
        vt[15] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b10, 2'b00, 2'b01, 2'b00);
        vt[16] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b10, 2'b00, 2'b01, 2'b00);
        vt[17] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b10, 2'b00, 2'b01, 2'b00);
        vt[18] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b10, 2'b01, 2'b01, 2'b00);
        vt[19] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b10, 2'b00, 2'b01, 2'b00);
        vt[20] = v(1, 1, 0, 0, 2'b00, 8'd9, 0, 1, 2'b11, 2'b00, 2'b01, 2'b00);
        vt[21] = v(1, 1, 0, 0, 2'b11, 8'd0, 0, 1, 2'b11, 2'b00, 2'b01, 2'b00);
        vt[22] = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b11);
        vt[23] = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 1, 2'b11, 2'b00, 2'b11, 2'b11);
        vt[24] = v(1, 1, 0, 0, 2'b00, 8'd0, 0, 1, 2'b00, 2'b00, 2'b11, 2'b11);
        vt[25] = v(1, 1, 0, 0, 2'b11, 8'd5, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00);
        vt[26] = v(1, 1, 0, 0, 2'b00, 8'd5, 0, 1, 2'b00, 2'b11, 2'b11, 2'b00);
        vt[27] = v(1, 1, 0, 0, 2'b00, 8'd5, 0, 1, 2'b00, 2'b00, 2'b11, 2'b00);
        vt[28] = v(1, 1, 0, 0, 2'b00, 8'd5, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00);
        vt[29] = v(1, 1, 0, 0, 2'b00, 8'd5, 0, 1, 2'b11, 2'b00, 2'b11, 2'b00);

        do_reset();
        run_table();
        run_brkpt_seq();
        run_midreset_seq();
        for (int r = 0; r < 4; r++) begin
            run_random(400);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_soc_ifc_rst_seq
`default_nettype wire
